ysyx_22040237_mdu: RTL and testbench

YSYX_22040237_MDU -- requirements
Module: ysyx_22040237_mdu

---
 rtl/ysyx_22040237_mdu_pkg.sv | 60 ++++++
 rtl/ysyx_22040237_mdu_sgn.sv | 13 +
 rtl/ysyx_22040237_mdu.sv | 227 ++++++++++++++++++++++
 tb/tb_ysyx_22040237_mdu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040237_mdu_pkg.sv
// Shared ysyx_22040237 defines: MDU op/state encodings, default XLEN,
// EXU info-bus constants and small op-decode helpers.
package ysyx_22040237_mdu_pkg;

   localparam int MDU_XLEN_DEF    = 64;

   // EXU info-bus constants shared with the execute stage
   localparam int EXU_INFO_RD_W   = 5;
   localparam int EXU_INFO_OP_W   = 3;
   localparam int EXU_INFO_FU_ALU = 0;
   localparam int EXU_INFO_FU_MDU = 1;
   localparam int EXU_INFO_FU_LSU = 2;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_FIX  = 2'd2,
      MDU_DONE = 2'd3
   } mdu_state_e;

   function automatic logic f_is_div(input mdu_op_e op);
      logic [2:0] v;
      v = op;
      return v[2];
   endfunction

   // remainder ops are the div ops with bit 1 set
   function automatic logic f_is_rem(input mdu_op_e op);
      logic [2:0] v;
      v = op;
      return v[2] & v[1];
   endfunction

   function automatic logic f_op1_signed(input mdu_op_e op);
      return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
             (op == MDU_DIV) || (op == MDU_REM);
   endfunction

   function automatic logic f_op2_signed(input mdu_op_e op);
      return (op == MDU_MUL) || (op == MDU_MULH) ||
             (op == MDU_DIV) || (op == MDU_REM);
   endfunction

   // word variants exist only for MUL and the four divide ops
   function automatic logic f_word_legal(input mdu_op_e op);
      return (op == MDU_MUL) || f_is_div(op);
   endfunction

endpackage

// File: rtl/ysyx_22040237_mdu_sgn.sv
// Conditional two's-complement negation, used both to take operand
// magnitudes and to re-apply the result sign.
module ysyx_22040237_mdu_sgn #(
   parameter int W = 64
) (
   input  logic [W-1:0] i_data,
   input  logic         i_neg,
   output logic [W-1:0] o_data
);

   assign o_data = i_neg ? (~i_data + W'(1'b1)) : i_data;

endmodule

// File: rtl/ysyx_22040237_mdu.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring
// divide, sign/magnitude handled around an unsigned core.
module ysyx_22040237_mdu
   import ysyx_22040237_mdu_pkg::*;
#(
   parameter int XLEN   = MDU_XLEN_DEF,
   parameter bit WOP_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [2:0]      op_i,
   input  logic            wop_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic [4:0]      rd_idx_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] res_o,
   output logic [4:0]      rd_idx_o,
   output logic            busy_o
);

   localparam int CW    = $clog2(XLEN) + 1;
   // word ops only make sense on a 64-bit datapath
   localparam bit L_WOP = (XLEN == 64) && WOP_EN;

   function automatic logic [XLEN-1:0] f_sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   mdu_state_e          r_state;
   logic [CW-1:0]       r_cnt;
   mdu_op_e             r_op;
   logic                r_wop, r_s1, r_s2;
   logic [4:0]          r_tag;
   logic [XLEN-1:0]     r_res, r_x;
   logic [2*XLEN-1:0]   r_acc, r_y;

   mdu_op_e             w_op;
   logic                w_wop, w_s1_en, w_s2_en, w_s1, w_s2;
   logic [XLEN-1:0]     w_op1_ext, w_op2_ext, w_mag1, w_mag2, w_dvd, w_min, w_byp_res;
   logic                w_accept, w_div_zero, w_ovf, w_bypass;
   logic [XLEN:0]       w_rem_sh, w_diff;
   logic [CW-1:0]       w_last;
   logic [2*XLEN-1:0]   w_post_in, w_post_out;
   logic                w_post_neg;
   logic [XLEN-1:0]     w_res_raw, w_res_fix;

   assign w_op     = mdu_op_e'(op_i);
   assign w_wop    = L_WOP & wop_i & f_word_legal(w_op);
   assign w_s1_en  = f_op1_signed(w_op);
   assign w_s2_en  = f_op2_signed(w_op);
   assign w_accept = in_valid_i & (r_state == MDU_IDLE) & ~flush_i;

   // Operand extension: word ops see only the low 32 bits
   always_comb begin
      w_op1_ext = op1_i;
      w_op2_ext = op2_i;
      if (w_wop) begin
         w_op1_ext = w_s1_en ? f_sext32(op1_i[31:0]) : XLEN'(op1_i[31:0]);
         w_op2_ext = w_s2_en ? f_sext32(op2_i[31:0]) : XLEN'(op2_i[31:0]);
      end else begin
         w_op1_ext = op1_i;
         w_op2_ext = op2_i;
      end
   end

   assign w_s1 = w_s1_en & w_op1_ext[XLEN-1];
   assign w_s2 = w_s2_en & w_op2_ext[XLEN-1];

   ysyx_22040237_mdu_sgn #(.W(XLEN)) u_sgn_op1 (.i_data(w_op1_ext), .i_neg(w_s1), .o_data(w_mag1));
   ysyx_22040237_mdu_sgn #(.W(XLEN)) u_sgn_op2 (.i_data(w_op2_ext), .i_neg(w_s2), .o_data(w_mag2));

   // Divide-by-zero and signed overflow skip the iterative datapath
   assign w_dvd      = w_wop ? f_sext32(op1_i[31:0]) : op1_i;
   assign w_min      = w_wop ? f_sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
   assign w_div_zero = (w_op2_ext == {XLEN{1'b0}});
   assign w_ovf      = ((w_op == MDU_DIV) || (w_op == MDU_REM)) &&
                       (w_op1_ext == w_min) && (w_op2_ext == {XLEN{1'b1}});
   assign w_bypass   = f_is_div(w_op) & (w_div_zero | w_ovf);

   // Bypass result: quotient/remainder for the two special divide cases
   always_comb begin
      w_byp_res = {XLEN{1'b0}};
      if (w_div_zero) begin
         w_byp_res = f_is_rem(w_op) ? w_dvd : {XLEN{1'b1}};
      end else begin
         w_byp_res = f_is_rem(w_op) ? {XLEN{1'b0}} : w_dvd;
      end
   end

   // Restoring divide step: {remainder, dividend} shift and trial subtract
   assign w_rem_sh = {r_acc[XLEN-1:0], r_x[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_y[XLEN-1:0]};
   assign w_last   = r_wop ? CW'(31) : CW'(XLEN - 1);

   // Post-conversion select: which magnitude gets which sign
   always_comb begin
      w_post_in  = r_acc;
      w_post_neg = r_s1 ^ r_s2;
      case (r_op)
         MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU: begin
            w_post_in  = r_acc;
            w_post_neg = r_s1 ^ r_s2;
         end
         MDU_DIV, MDU_DIVU: begin
            w_post_in  = {{XLEN{1'b0}}, r_x};
            w_post_neg = r_s1 ^ r_s2;
         end
         MDU_REM, MDU_REMU: begin
            w_post_in  = {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
            w_post_neg = r_s1;
         end
         default: begin
            w_post_in  = r_acc;
            w_post_neg = 1'b0;
         end
      endcase
   end

   ysyx_22040237_mdu_sgn #(.W(2*XLEN)) u_sgn_res (.i_data(w_post_in), .i_neg(w_post_neg), .o_data(w_post_out));

   // Final result: low half for MUL/div ops, high half for MULH*, word sign-extension
   always_comb begin
      if ((r_op == MDU_MUL) || f_is_div(r_op)) begin
         w_res_raw = w_post_out[XLEN-1:0];
      end else begin
         w_res_raw = w_post_out[2*XLEN-1:XLEN];
      end
      if (r_wop) begin
         w_res_fix = f_sext32(w_res_raw[31:0]);
      end else begin
         w_res_fix = w_res_raw;
      end
   end

   // Control FSM, iteration counter and shift datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= MDU_IDLE;
         r_cnt   <= {CW{1'b0}};
         r_op    <= MDU_MUL;
         r_wop   <= 1'b0;
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_tag   <= 5'd0;
         r_res   <= {XLEN{1'b0}};
         r_x     <= {XLEN{1'b0}};
         r_acc   <= {(2*XLEN){1'b0}};
         r_y     <= {(2*XLEN){1'b0}};
      end else if (flush_i) begin
         r_state <= MDU_IDLE;
         r_cnt   <= {CW{1'b0}};
      end else begin
         case (r_state)
            MDU_IDLE: begin
               if (w_accept) begin
                  r_op  <= w_op;
                  r_wop <= w_wop;
                  r_s1  <= w_s1;
                  r_s2  <= w_s2;
                  r_tag <= rd_idx_i;
                  r_cnt <= {CW{1'b0}};
                  r_acc <= {(2*XLEN){1'b0}};
                  if (f_is_div(w_op)) begin
                     // left-align a word dividend so quotient bits land in [31:0]
                     r_x <= w_wop ? (w_mag1 << (XLEN - 32)) : w_mag1;
                     r_y <= {{XLEN{1'b0}}, w_mag2};
                  end else begin
                     r_x <= w_mag2;
                     r_y <= {{XLEN{1'b0}}, w_mag1};
                  end
                  if (w_bypass) begin
                     r_res   <= w_byp_res;
                     r_state <= MDU_DONE;
                  end else begin
                     r_state <= MDU_CALC;
                  end
               end
            end
            MDU_CALC: begin
               if (f_is_div(r_op)) begin
                  if (!w_diff[XLEN]) begin
                     r_acc <= {{XLEN{1'b0}}, w_diff[XLEN-1:0]};
                     r_x   <= {r_x[XLEN-2:0], 1'b1};
                  end else begin
                     r_acc <= {{XLEN{1'b0}}, w_rem_sh[XLEN-1:0]};
                     r_x   <= {r_x[XLEN-2:0], 1'b0};
                  end
               end else begin
                  if (r_x[0]) begin
                     r_acc <= r_acc + r_y;
                  end
                  r_y <= r_y << 1;
                  r_x <= r_x >> 1;
               end
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == w_last) begin
                  r_state <= MDU_FIX;
               end
            end
            MDU_FIX: begin
               r_res   <= w_res_fix;
               r_state <= MDU_DONE;
            end
            MDU_DONE: begin
               if (out_ready_i) begin
                  r_state <= MDU_IDLE;
               end
            end
            default: begin
               r_state <= MDU_IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = (r_state == MDU_IDLE);
   assign out_valid_o = (r_state == MDU_DONE);
   assign busy_o      = (r_state != MDU_IDLE);
   assign res_o       = r_res;
   assign rd_idx_o    = r_tag;

endmodule

// File: tb/tb_ysyx_22040237_mdu.sv
// Directed self-checking bench for the iterative MDU (XLEN=64).
module tb_ysyx_22040237_mdu;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_i, in_ready_o, wop_i, flush_i, out_valid_o, out_ready_i, busy_o;
   logic [2:0]  op_i;
   logic [63:0] op1_i, op2_i, res_o;
   logic [4:0]  rd_idx_i, rd_idx_o;

   int checks   = 0;
   int failures = 0;

   ysyx_22040237_mdu #(.XLEN(64), .WOP_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .op_i(op_i), .wop_i(wop_i), .op1_i(op1_i), .op2_i(op2_i), .rd_idx_i(rd_idx_i),
      .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .res_o(res_o), .rd_idx_o(rd_idx_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // Issue one request from IDLE, wait (bounded) for out_valid; retire it if out_ready_i is high.
   // lat = index of the first cycle after the accept edge showing out_valid (1 = next cycle).
   task automatic do_op(input logic [2:0] op, input logic wop, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, output logic [63:0] res, output logic [4:0] tag_o, output int lat);
      in_valid_i = 1'b1; op_i = op; wop_i = wop; op1_i = a; op2_i = b; rd_idx_i = tag;
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      lat = 1;
      while (!out_valid_o && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = res_o; tag_o = rd_idx_o;
      if (out_valid_o && out_ready_i) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; #1;
      checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      checks++; if (res_o !== 64'd0) begin failures++; $display("FAIL reset_res got=%h exp=0", res_o); end
      checks++; if (rd_idx_o !== 5'd0) begin failures++; $display("FAIL reset_rd_idx got=%0d exp=0", rd_idx_o); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      logic [63:0] r; logic [4:0] t; int lat;
      do_op(OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, r, t, lat);
      checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL mul_7xm3 got=%h exp=ffffffffffffffeb", r); end
      checks++; if (lat !== 66) begin failures++; $display("FAIL mul_latency got=%0d exp=66", lat); end
      checks++; if (t !== 5'd5) begin failures++; $display("FAIL mul_tag got=%0d exp=5", t); end
      do_op(OP_MULHU, 1'b0, ONES, ONES, 5'd6, r, t, lat);
      checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulhu_ones got=%h exp=fffffffffffffffe", r); end
      do_op(OP_MULHSU, 1'b0, ONES, 64'd2, 5'd7, r, t, lat);
      checks++; if (r !== ONES) begin failures++; $display("FAIL mulhsu_m1x2 got=%h exp=ffffffffffffffff", r); end
      do_op(OP_MULH, 1'b0, ONES, ONES, 5'd8, r, t, lat);
      checks++; if (r !== 64'd0) begin failures++; $display("FAIL mulh_m1xm1 got=%h exp=0", r); end
      do_op(OP_MUL, 1'b1, 64'hDEAD_0000_7FFF_FFFF, 64'h1234_0000_0000_0002, 5'd9, r, t, lat);
      checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulw got=%h exp=fffffffffffffffe", r); end
      checks++; if (lat !== 34) begin failures++; $display("FAIL mulw_latency got=%0d exp=34", lat); end
   endtask

   task automatic test_div();
      logic [63:0] r; logic [4:0] t; int lat;
      do_op(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, r, t, lat);
      checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_m7_2 got=%h exp=fffffffffffffffd", r); end
      checks++; if (lat !== 66) begin failures++; $display("FAIL div_latency got=%0d exp=66", lat); end
      do_op(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, r, t, lat);
      checks++; if (r !== ONES) begin failures++; $display("FAIL rem_m7_2 got=%h exp=ffffffffffffffff", r); end
      do_op(OP_DIVU, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 5'd12, r, t, lat);
      checks++; if (r !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL divuw got=%h exp=ffffffff80000000", r); end
      checks++; if (lat !== 34) begin failures++; $display("FAIL divuw_latency got=%0d exp=34", lat); end
      do_op(OP_REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hAAAA_0000_0000_0002, 5'd13, r, t, lat);
      checks++; if (r !== ONES) begin failures++; $display("FAIL remw_m7_2 got=%h exp=ffffffffffffffff", r); end
      do_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd14, r, t, lat);
      checks++; if (r !== 64'd14) begin failures++; $display("FAIL divu_100_7 got=%h exp=e", r); end
      do_op(OP_REMU, 1'b0, 64'd100, 64'd7, 5'd15, r, t, lat);
      checks++; if (r !== 64'd2) begin failures++; $display("FAIL remu_100_7 got=%h exp=2", r); end
   endtask

   task automatic test_div_bypass();
      logic [63:0] r; logic [4:0] t; int lat;
      do_op(OP_DIVU, 1'b0, 64'd5, 64'd0, 5'd16, r, t, lat);
      checks++; if (r !== ONES) begin failures++; $display("FAIL divu_by0 got=%h exp=ffffffffffffffff", r); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL divu_by0_latency got=%0d exp=1", lat); end
      do_op(OP_REM, 1'b0, 64'd5, 64'd0, 5'd17, r, t, lat);
      checks++; if (r !== 64'd5) begin failures++; $display("FAIL rem_by0 got=%h exp=5", r); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL rem_by0_latency got=%0d exp=1", lat); end
      do_op(OP_DIV, 1'b0, 64'h8000_0000_0000_0000, ONES, 5'd18, r, t, lat);
      checks++; if (r !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL div_ovf got=%h exp=8000000000000000", r); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL div_ovf_latency got=%0d exp=1", lat); end
      do_op(OP_REM, 1'b0, 64'h8000_0000_0000_0000, ONES, 5'd19, r, t, lat);
      checks++; if (r !== 64'd0) begin failures++; $display("FAIL rem_ovf got=%h exp=0", r); end
      do_op(OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd20, r, t, lat);
      checks++; if (r !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL divw_ovf got=%h exp=ffffffff80000000", r); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL divw_ovf_latency got=%0d exp=1", lat); end
      do_op(OP_REMU, 1'b1, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 5'd21, r, t, lat);
      checks++; if (r !== 64'hFFFF_FFFF_8000_0005) begin failures++; $display("FAIL remuw_by0 got=%h exp=ffffffff80000005", r); end
   endtask

   task automatic test_hold();
      logic [63:0] r; logic [4:0] t; int lat;
      out_ready_i = 1'b0;
      do_op(OP_MUL, 1'b0, 64'd3, 64'd5, 5'd9, r, t, lat);
      checks++; if (r !== 64'd15) begin failures++; $display("FAIL hold_res got=%h exp=f", r); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (res_o !== 64'd15) begin failures++; $display("FAIL hold_res_stable cyc=%0d got=%h exp=f", i, res_o); end
         checks++; if (rd_idx_o !== 5'd9) begin failures++; $display("FAIL hold_tag_stable cyc=%0d got=%0d exp=9", i, rd_idx_o); end
         checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready_o); end
         checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", i, out_valid_o); end
      end
      out_ready_i = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL hold_retire got=%b exp=0", out_valid_o); end
   endtask

   task automatic test_flush();
      int seen;
      // request presented together with flush is dropped
      in_valid_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; wop_i = 1'b0; op1_i = 64'd100; op2_i = 64'd7; rd_idx_i = 5'd22;
      @(posedge clk); #1;
      in_valid_i = 1'b0; flush_i = 1'b0;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_blocks_accept busy got=%b exp=0", busy_o); end
      in_valid_i = 1'b1;
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL flush_accept busy got=%b exp=1", busy_o); end
      repeat (4) @(posedge clk);
      #1; flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy_o); end
      checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready_o); end
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         if (out_valid_o) seen++;
         @(posedge clk); #1;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_result got=%0d exp=0", seen); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] r; logic [4:0] t; int lat;
      in_valid_i = 1'b1; op_i = OP_MUL; wop_i = 1'b0; op1_i = 64'd7; op2_i = 64'd3; rd_idx_i = 5'd3;
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      repeat (9) @(posedge clk);
      #1; rst = 1'b0; #1;
      checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready_o); end
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
      checks++; if (res_o !== 64'd0) begin failures++; $display("FAIL rstmid_res got=%h exp=0", res_o); end
      checks++; if (rd_idx_o !== 5'd0) begin failures++; $display("FAIL rstmid_rd_idx got=%0d exp=0", rd_idx_o); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      do_op(OP_MUL, 1'b0, 64'd6, 64'd7, 5'd12, r, t, lat);
      checks++; if (r !== 64'd42) begin failures++; $display("FAIL rstmid_next_res got=%h exp=2a", r); end
      checks++; if (t !== 5'd12) begin failures++; $display("FAIL rstmid_next_tag got=%0d exp=12", t); end
      checks++; if (lat !== 66) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=66", lat); end
   endtask

   task automatic test_back_to_back();
      in_valid_i = 1'b1; op_i = OP_DIVU; wop_i = 1'b0; op1_i = 64'd9; op2_i = 64'd0; rd_idx_i = 5'd1;
      @(posedge clk); #1;
      checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%b exp=1", out_valid_o); end
      // next request held valid while the first one retires
      op_i = OP_REMU; rd_idx_i = 5'd2;
      @(posedge clk); #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap busy got=%b exp=0", busy_o); end
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got=%b exp=1", out_valid_o); end
      checks++; if (res_o !== 64'd9) begin failures++; $display("FAIL b2b_second_res got=%h exp=9", res_o); end
      checks++; if (rd_idx_o !== 5'd2) begin failures++; $display("FAIL b2b_second_tag got=%0d exp=2", rd_idx_o); end
      @(posedge clk); #1;
   endtask

   initial begin
      in_valid_i = 1'b0; op_i = 3'd0; wop_i = 1'b0; op1_i = 64'd0; op2_i = 64'd0;
      rd_idx_i = 5'd0; flush_i = 1'b0; out_ready_i = 1'b1;
      test_reset();
      test_mul();
      test_div();
      test_div_bypass();
      test_hold();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
